bcd_counter_chain: RTL and testbench



---
 rtl/bcd_counter_chain.sv | 101 ++++++++++
 tb/tb_bcd_counter_chain.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_chain.sv
// Cascaded multi-digit up/down counter with per-digit modulus RADIX, synchronous
// load with illegal-digit clamping, optional saturation and registered wrap pulses.
module bcd_counter_chain #(
    parameter int DIGITS   = 4,
    parameter int RADIX    = 10,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] digits_out,
    output logic                carry_out,
    output logic                borrow_out,
    output logic                at_max,
    output logic                at_zero
);

    localparam int         W         = 4 * DIGITS;
    localparam logic [3:0] MAX_DIGIT = 4'(RADIX - 1);

    logic [W-1:0] digits_p1;
    logic         carry_p1;
    logic         borrow_p1;

    logic [W-1:0] digits_nxt;
    logic         carry_nxt;
    logic         borrow_nxt;
    logic         all_max;
    logic         all_zero;
    logic         terminal;
    logic         ripple;
    logic [3:0]   cur_digit;

    // Digits outside 0..RADIX-1 can only arrive through load; force them to 0.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > MAX_DIGIT) ? 4'd0 : d;
    endfunction

    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic dir_up);
        if (dir_up)
            return (d == MAX_DIGIT) ? 4'd0 : d + 4'd1;
        else
            return (d == 4'd0) ? MAX_DIGIT : d - 4'd1;
    endfunction

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            all_max  = all_max  & (digits_p1[4*i +: 4] == MAX_DIGIT);
            all_zero = all_zero & (digits_p1[4*i +: 4] == 4'd0);
        end
    end

    // The ripple enable is resolved combinationally across all digits so a
    // cascade of any length completes in a single clock.
    always_comb begin
        digits_nxt = digits_p1;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        terminal   = up ? all_max : all_zero;
        ripple     = 1'b1;
        cur_digit  = 4'd0;
        if (load) begin
            for (int i = 0; i < DIGITS; i++)
                digits_nxt[4*i +: 4] = clamp_digit(load_val[4*i +: 4]);
        end else if (en && !(SATURATE != 0 && terminal)) begin
            for (int i = 0; i < DIGITS; i++) begin
                cur_digit = digits_p1[4*i +: 4];
                if (ripple)
                    digits_nxt[4*i +: 4] = step_digit(cur_digit, up);
                ripple = ripple & (up ? (cur_digit == MAX_DIGIT) : (cur_digit == 4'd0));
            end
            carry_nxt  = up & all_max;
            borrow_nxt = ~up & all_zero;
        end
    end

    // ---- register stage ----
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_p1 <= '0;
            carry_p1  <= 1'b0;
            borrow_p1 <= 1'b0;
        end else begin
            digits_p1 <= digits_nxt;
            carry_p1  <= carry_nxt;
            borrow_p1 <= borrow_nxt;
        end
    end

    assign digits_out = digits_p1;
    assign carry_out  = carry_p1;
    assign borrow_out = borrow_p1;
    assign at_max     = all_max;
    assign at_zero    = all_zero;

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench: three counter configurations share one stimulus stream and are
// checked every cycle against an integer-valued reference model of the counter.
module tb_bcd_counter_chain;

    logic        clk = 1'b0;
    logic        reset, en, up, load;
    logic [15:0] load_val;

    logic [15:0] a_dig, b_dig;
    logic [7:0]  c_dig;
    logic        a_c, a_b, a_mx, a_z;
    logic        b_c, b_b, b_mx, b_z;
    logic        c_c, c_b, c_mx, c_z;

    always #5 clk = ~clk;

    bcd_counter_chain #(.DIGITS(4), .RADIX(10), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .digits_out(a_dig), .carry_out(a_c), .borrow_out(a_b), .at_max(a_mx), .at_zero(a_z));

    bcd_counter_chain #(.DIGITS(4), .RADIX(10), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .digits_out(b_dig), .carry_out(b_c), .borrow_out(b_b), .at_max(b_mx), .at_zero(b_z));

    bcd_counter_chain #(.DIGITS(2), .RADIX(6), .SATURATE(0)) u_r6 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[7:0]),
        .digits_out(c_dig), .carry_out(c_c), .borrow_out(c_b), .at_max(c_mx), .at_zero(c_z));

    typedef struct {
        int          inst;
        logic [15:0] dig;
        logic        c, b, mx, z;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int   md[3] = '{4, 4, 2};
    int   mr[3] = '{10, 10, 6};
    int   ms[3] = '{0, 1, 0};
    int   mval[3] = '{0, 0, 0};

    function automatic int ipow(int b, int e);
        int p = 1;
        for (int i = 0; i < e; i++) p = p * b;
        return p;
    endfunction

    function automatic logic [15:0] to_nib(int v, int d, int r);
        logic [15:0] res = '0;
        int          t   = v;
        for (int i = 0; i < d; i++) begin
            res[4*i +: 4] = 4'(t % r);
            t = t / r;
        end
        return res;
    endfunction

    // Counter treated as a plain integer in 0 .. RADIX^DIGITS-1.
    function automatic exp_t model_next(int k, bit r, bit e, bit u, bit l, logic [15:0] lv);
        exp_t x;
        int   top = ipow(mr[k], md[k]) - 1;
        int   v   = mval[k];
        int   dg;
        x.c = 1'b0;
        x.b = 1'b0;
        if (r) begin
            v = 0;
        end else if (l) begin
            v = 0;
            for (int i = md[k] - 1; i >= 0; i--) begin
                dg = int'(lv[4*i +: 4]);
                if (dg >= mr[k]) dg = 0;
                v = v * mr[k] + dg;
            end
        end else if (e) begin
            if (u) begin
                if (v < top) v = v + 1;
                else if (ms[k] == 0) begin v = 0; x.c = 1'b1; end
            end else begin
                if (v > 0) v = v - 1;
                else if (ms[k] == 0) begin v = top; x.b = 1'b1; end
            end
        end
        mval[k] = v;
        x.inst  = k;
        x.dig   = to_nib(v, md[k], mr[k]);
        x.mx    = (v == top);
        x.z     = (v == 0);
        return x;
    endfunction

    task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [15:0] lv);
        exp_t nx[3];
        reset = r; en = e; up = u; load = l; load_val = lv;
        for (int k = 0; k < 3; k++) nx[k] = model_next(k, r, e, u, l, lv);
        @(posedge clk);
        for (int k = 0; k < 3; k++) sb_q.push_back(nx[k]);
        #1;
    endtask

    task automatic run(input int n, input bit u);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, u, 1'b0, 16'h0);
    endtask

    logic [15:0] act_dig;
    logic        act_c, act_b, act_mx, act_z;
    exp_t        cur;

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            case (cur.inst)
                0:       begin act_dig = a_dig; act_c = a_c; act_b = a_b; act_mx = a_mx; act_z = a_z; end
                1:       begin act_dig = b_dig; act_c = b_c; act_b = b_b; act_mx = b_mx; act_z = b_z; end
                default: begin act_dig = {8'h00, c_dig}; act_c = c_c; act_b = c_b; act_mx = c_mx; act_z = c_z; end
            endcase
            checks++;
            if (act_dig !== cur.dig || act_c !== cur.c || act_b !== cur.b ||
                act_mx !== cur.mx || act_z !== cur.z) begin
                errors++;
                $display("FAIL sb inst%0d t=%0t actual dig=%h c=%b b=%b max=%b zero=%b required dig=%h c=%b b=%b max=%b zero=%b",
                         cur.inst, $time, act_dig, act_c, act_b, act_mx, act_z,
                         cur.dig, cur.c, cur.b, cur.mx, cur.z);
            end
        end
    end

    logic [15:0] picks[6] = '{16'h9999, 16'h0000, 16'h9998, 16'h0001, 16'h0055, 16'h1000};

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // reset mid-count
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0357);
        run(3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // up-wrap with single-cycle carry
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
        run(1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // down ripple to zero and borrow wrap
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        run(1001, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // saturation at top, then one step down
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9998);
        run(3, 1'b1);
        run(1, 1'b0);

        // load clamp over en, load with reset, wrap suppressed by reset and load
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0C0A);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h9999);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h9955);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        // radix-6 full cycle plus direction flips
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        run(40, 1'b1);
        run(5, 1'b0);
        run(5, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic [15:0] lv;
            lv = ($urandom_range(0, 1) == 0) ? 16'($urandom) : picks[$urandom_range(0, 5)];
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, lv);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
